serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial adder that sits directly upstream of the 1-bit full-adder cell and drives it. It accepts two WIDTH-bit operands plus carry-in, presents one bit pair per clock (LSB first) to a single full-adder cell, and registers the carry between cycles. It reassembles the sum bits into a parallel result with carry-out. It trades WIDTH cycles of latency for one adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin an addition; sampled only in IDLE.
a  input  WIDTH  operand A; captured on the accepted start edge.
b  input  WIDTH  operand B; captured on the accepted start edge.
cin  input  1  carry-in; captured on the accepted start edge.
busy  output  1  high in RUN and DONE; start is ignored while high.
done  output  1  single-cycle pulse when the result becomes valid.
sum  output  WIDTH  registered result; holds its value until the next completion.
cout  output  1  registered carry-out; holds its value until the next completion.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst; polarity and synchronicity are fixed.
- Reset values:
  - state = IDLE, busy = 0, done = 0, sum = 0, cout = 0.
  - Internal carry register, bit counter and shift registers = 0.
- States:
  - IDLE: if start = 1, load a_sr <= a, b_sr <= b, carry <= cin, cnt <= 0, then go to RUN. If start = 0, stay.
  - RUN, each edge:
    - Cell inputs are (a_sr[0], b_sr[0], carry).
    - Shift a_sr and b_sr right by 1.
    - Shift the cell sum into acc MSB (acc <= {s, acc[WIDTH-1:1]}).
    - carry <= cell cout; cnt <= cnt + 1.
    - When cnt = WIDTH-1: sum <= {s, acc[WIDTH-1:1]}, cout <= cell cout, go to DONE.
  - DONE: done = 1 for exactly this cycle; next edge returns to IDLE.
- Latency: start sampled at the edge closing cycle T. RUN occupies cycles T+1..T+WIDTH. done = 1 and sum/cout are valid in cycle T+WIDTH+1. Total WIDTH+1 cycles, start to done.
- Throughput: the next start is accepted at the earliest in cycle T+WIDTH+2 (the first IDLE cycle). Back-to-back period is WIDTH+2 cycles.
- Start asserted in RUN or DONE is ignored; it is not queued.
- Operand inputs are don't-care except on the accepted start edge.
- Reset mid-operation aborts the operation: no done pulse, and sum/cout return to 0.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a + b + cin.
- The counter is $clog2(WIDTH) bits wide and wraps only via reload; it never counts past WIDTH-1.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset value 0, registered alongside sum.
  - ovf = carry into MSB XOR carry out of MSB (two's-complement overflow), captured at the cnt = WIDTH-1 step.
  - Holds its value like sum.
- Undefined: no ovf port and no associated logic.

Decomposition:
- Package serial_adder_pkg:
  - State encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Default width constant SA_WIDTH_DEF = 8.
  - Counter-width function/constant derived from WIDTH.
- Sub-module fa_cell: purely combinational 1-bit full adder (a, b, cin -> s, co), instantiated once.
- Everything else (FSM, shift registers, counter, output registers) lives in serial_adder.

Test Plan:
- Sum, no carry-out: WIDTH=8, a=0x5A, b=0x3C, cin=0, start in cycle T -> busy high T+1..T+9, done only in T+9, sum=0x96, cout=0.
- Carry ripple through all bits: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. With a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start while busy: start held high for 12 cycles with a=0x01, b=0x02 -> exactly one done, sum=0x03. A second operation is accepted in the first IDLE cycle, T+10.
- Reset mid-operation: rst=1 in cycle T+4 -> no done; sum=0, cout=0, busy=0. A new start with a=0x10, b=0x20 -> sum=0x30.
- Hold behaviour: after a result of 0x96, change a/b with start=0 for 20 cycles -> sum stays 0x96, done stays 0.
- Overflow (SERIAL_ADDER_OVF_EN defined): a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1. a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int unsigned SA_WIDTH_DEF = 8;

    function automatic int unsigned sa_cnt_w(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH+1 cycles start to done.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned         CNT_W    = sa_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    sa_state_t        w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Only acc[WIDTH-1:1] is ever observed, so bit 0 is not stored.
    logic [WIDTH-1:1] r_acc;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_co;
    logic             w_last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    fa_cell u_fa (
        .a   (r_a_sr[0]),
        .b   (r_b_sr[0]),
        .cin (r_carry),
        .s   (w_s),
        .co  (w_co)
    );

    assign w_last     = (r_cnt == CNT_LAST);
    assign w_acc_next = {w_s, r_acc};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_acc   <= w_acc_next[WIDTH-1:1];
                    r_carry <= w_co;
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf  <= r_carry ^ w_co;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected results, negedge monitor checks.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   acc_cyc  = -1000;
    int   free_cyc = 0;
    bit   model_on = 1'b0;
    bit   prev_rst = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // One clock of stimulus; the reference model decides acceptance from cycle arithmetic.
    task automatic drive(input bit st, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input bit ic, input bit ir);
        logic [W:0] t;
        exp_t       e;
        @(posedge clk);
        #1;
        if (prev_rst) begin
            q.delete();
            held.s   = '0;
            held.c   = 1'b0;
            held.v   = 1'b0;
            held.due = 0;
            acc_cyc  = -1000;
            free_cyc = cyc;
            model_on = 1'b1;
        end
        start    = st;
        a        = ia;
        b        = ib;
        cin      = ic;
        rst      = ir;
        prev_rst = ir;
        if (st && !ir && cyc >= free_cyc) begin
            t     = {1'b0, ia} + {1'b0, ib} + (W+1)'(ic);
            e.s   = t[W-1:0];
            e.c   = t[W];
            e.v   = (ia[W-1] == ib[W-1]) && (t[W-1] != ia[W-1]);
            e.due = cyc + W + 1;
            q.push_back(e);
            acc_cyc  = cyc;
            free_cyc = cyc + W + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit ic);
        drive(1'b1, ia, ib, ic, 1'b0);
        idle(W + 1);
    endtask

    always @(negedge clk) begin
        bit ed;
        if (model_on) begin
            ed = (q.size() > 0) && (q[0].due == cyc);
            check("done", 64'(done), 64'(ed));
            if (ed) held = q.pop_front();
            check("sum", 64'(sum), 64'(held.s));
            check("cout", 64'(cout), 64'(held.c));
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", 64'(ovf), 64'(held.v));
`endif
            check("busy", 64'(busy), 64'((cyc > acc_cyc) && (cyc <= acc_cyc + int'(W) + 1)));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);

        op(8'h5A, 8'h3C, 1'b0);
        idle(20);

        op(8'hFF, 8'h01, 1'b0);
        op(8'hFF, 8'hFF, 1'b1);

        for (int i = 0; i < 12; i++) drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        idle(W + 2);

        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        op(8'h10, 8'h20, 1'b0);

        op(8'h7F, 8'h01, 1'b0);
        op(8'h80, 8'h80, 1'b0);
        op(8'h05, 8'h03, 1'b0);
        op(8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 2) == 0, W'($urandom), W'($urandom),
                  1'($urandom), $urandom_range(0, 99) == 0);
        idle(W + 3);

        check("drain", 64'(q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
